// File: rtl/pbus_fetch.sv
// -----------------------------------------------------------------------------
// pbus_fetch
//
// Purpose:
//   Cartridge fetch sequencer for the multiplexed PBUS. It accepts one pending
//   sprite request and one pending fix request. It runs one bus transaction at
//   a time. When both kinds are waiting, it alternates between them.
//
//   Each transaction walks the state sequence IDLE -> ADDR -> PULSE -> HOLD ->
//   WAIT(n) -> IDLE:
//     - The address is driven from ADDR entry onward.
//     - The matching address latch (PCK1B or PCK2B) goes low for the PULSE
//       cycle. It rises again on HOLD entry, and the cartridge latches the
//       address on that rising edge.
//     - After the WAIT cycles, the cartridge data bus is captured and a
//       one-cycle VALID strobe is raised.
//
// Parameters:
//   SPR_WAIT  cycles from PCK1B rising edge to CR capture   (1..15)
//   FIX_WAIT  cycles from PCK2B rising edge to FIXD capture (1..15)
//
// Ports:
//   CLK_24M    in   1   clock, all state on rising edge
//   nRESET     in   1   asynchronous active-low reset
//   SPR_REQ    in   1   sprite fetch request (accepted when SPR_READY=1)
//   SPR_TILE   in  16   sprite tile number
//   SPR_LINE   in   4   sprite line within tile
//   SPR_HALF   in   1   sprite half select (driven onto CA4)
//   SPR_READY  out  1   sprite request slot free
//   SPR_DATA   out 32   captured sprite bitplane word
//   SPR_VALID  out  1   one-cycle strobe, SPR_DATA fresh
//   FIX_REQ    in   1   fix fetch request (accepted when FIX_READY=1)
//   FIX_TILE   in  12   fix tile number
//   FIX_LINE   in   3   fix line within tile
//   FIX_HALF   in   1   fix column half (driven onto S2H1)
//   FIX_READY  out  1   fix request slot free
//   FIX_DATA   out  8   captured fix byte
//   FIX_VALID  out  1   one-cycle strobe, FIX_DATA fresh
//   PBUS       out 20   multiplexed cartridge address
//   CA4        out  1   sprite half select to cartridge
//   S2H1       out  1   fix half select to cartridge
//   PCK1B      out  1   sprite address latch, idle high
//   PCK2B      out  1   fix address latch, idle high
//   CR         in  32   sprite data from cartridge
//   FIXD       in   8   fix data from cartridge
// -----------------------------------------------------------------------------
module pbus_fetch #(
    parameter int unsigned SPR_WAIT = 3,
    parameter int unsigned FIX_WAIT = 2
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        SPR_REQ,
    input  logic [15:0] SPR_TILE,
    input  logic [3:0]  SPR_LINE,
    input  logic        SPR_HALF,
    output logic        SPR_READY,
    output logic [31:0] SPR_DATA,
    output logic        SPR_VALID,
    input  logic        FIX_REQ,
    input  logic [11:0] FIX_TILE,
    input  logic [2:0]  FIX_LINE,
    input  logic        FIX_HALF,
    output logic        FIX_READY,
    output logic [7:0]  FIX_DATA,
    output logic        FIX_VALID,
    output logic [19:0] PBUS,
    output logic        CA4,
    output logic        S2H1,
    output logic        PCK1B,
    output logic        PCK2B,
    input  logic [31:0] CR,
    input  logic [7:0]  FIXD
);

    localparam logic [3:0] SPR_WAIT_4 = 4'(SPR_WAIT);
    localparam logic [3:0] FIX_WAIT_4 = 4'(FIX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        spr_pending, fix_pending;
    logic        last_fix;
    logic        cur_fix;
    logic [3:0]  wait_cnt;
    logic [15:0] spr_tile_q;
    logic [3:0]  spr_line_q;
    logic        spr_half_q;
    logic [11:0] fix_tile_q;
    logic [2:0]  fix_line_q;
    logic        fix_half_q;
    logic        start_spr, start_fix, wait_done;
    logic        spr_accept, fix_accept;

    // A pending flag covers both "queued" and "in flight". It is cleared only
    // on capture, so READY is simply its inverse.
    assign SPR_READY  = ~spr_pending;
    assign FIX_READY  = ~fix_pending;
    assign spr_accept = SPR_REQ & ~spr_pending;
    assign fix_accept = FIX_REQ & ~fix_pending;

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration works only from registered pending flags. A request
    // accepted on this edge therefore first competes in the next IDLE cycle.
    // When both kinds are pending, the sprite wins unless a sprite was served
    // last.
    always_comb begin
        state_d   = state_q;
        start_spr = 1'b0;
        start_fix = 1'b0;
        wait_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (spr_pending && (!fix_pending || last_fix)) begin
                    start_spr = 1'b1;
                    state_d   = S_ADDR;
                end else if (fix_pending) begin
                    start_fix = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR:  state_d = S_PULSE;
            S_PULSE: state_d = S_HOLD;
            S_HOLD:  state_d = S_WAIT;
            S_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    wait_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and bus outputs.
    // All outputs are registered so that the cartridge sees glitch-free
    // PBUS and latch strobes. Address and half-select are loaded on the
    // IDLE->ADDR edge and are left untouched until the next start.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            spr_pending <= 1'b0;
            fix_pending <= 1'b0;
            last_fix    <= 1'b1;
            cur_fix     <= 1'b0;
            wait_cnt    <= 4'd0;
            spr_tile_q  <= 16'd0;
            spr_line_q  <= 4'd0;
            spr_half_q  <= 1'b0;
            fix_tile_q  <= 12'd0;
            fix_line_q  <= 3'd0;
            fix_half_q  <= 1'b0;
            PBUS        <= 20'd0;
            CA4         <= 1'b0;
            S2H1        <= 1'b0;
            PCK1B       <= 1'b1;
            PCK2B       <= 1'b1;
            SPR_DATA    <= 32'd0;
            FIX_DATA    <= 8'd0;
            SPR_VALID   <= 1'b0;
            FIX_VALID   <= 1'b0;
        end else begin
            SPR_VALID <= 1'b0;
            FIX_VALID <= 1'b0;

            if (spr_accept) begin
                spr_pending <= 1'b1;
                spr_tile_q  <= SPR_TILE;
                spr_line_q  <= SPR_LINE;
                spr_half_q  <= SPR_HALF;
            end
            if (fix_accept) begin
                fix_pending <= 1'b1;
                fix_tile_q  <= FIX_TILE;
                fix_line_q  <= FIX_LINE;
                fix_half_q  <= FIX_HALF;
            end

            if (start_spr) begin
                cur_fix  <= 1'b0;
                last_fix <= 1'b0;
                PBUS     <= {spr_tile_q, spr_line_q};
                CA4      <= spr_half_q;
            end
            if (start_fix) begin
                cur_fix  <= 1'b1;
                last_fix <= 1'b1;
                PBUS     <= {4'b0000, fix_tile_q, fix_line_q, 1'b0};
                S2H1     <= fix_half_q;
            end

            // Only the latch that belongs to the active kind drops, and only
            // for the PULSE cycle. Its rise on HOLD entry is the latch edge.
            if (state_q == S_ADDR) begin
                PCK1B <= cur_fix;
                PCK2B <= ~cur_fix;
            end
            if (state_q == S_PULSE) begin
                PCK1B <= 1'b1;
                PCK2B <= 1'b1;
            end

            if (state_q == S_HOLD) begin
                wait_cnt <= cur_fix ? FIX_WAIT_4 : SPR_WAIT_4;
            end
            if (state_q == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (wait_done) begin
                if (cur_fix) begin
                    FIX_DATA    <= FIXD;
                    FIX_VALID   <= 1'b1;
                    fix_pending <= 1'b0;
                end else begin
                    SPR_DATA    <= CR;
                    SPR_VALID   <= 1'b1;
                    spr_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pbus_fetch.sv
// -----------------------------------------------------------------------------
// tb_pbus_fetch
//
// Purpose:
//   Directed, self-checking bench for pbus_fetch with default wait parameters
//   (sprite 3, fix 2).
//
//   Cycle index k counts clock edges after the accepting edge. Outputs are
//   sampled 1 time unit after each rising edge. With an empty FSM:
//     k=1          ADDR
//     k=2          PULSE (latch low)
//     k=3          HOLD
//     k=4 ..       WAIT
//     k=4+WAIT     VALID high
// -----------------------------------------------------------------------------
module tb_pbus_fetch;

    logic        CLK_24M;
    logic        nRESET;
    logic        SPR_REQ;
    logic [15:0] SPR_TILE;
    logic [3:0]  SPR_LINE;
    logic        SPR_HALF;
    logic        SPR_READY;
    logic [31:0] SPR_DATA;
    logic        SPR_VALID;
    logic        FIX_REQ;
    logic [11:0] FIX_TILE;
    logic [2:0]  FIX_LINE;
    logic        FIX_HALF;
    logic        FIX_READY;
    logic [7:0]  FIX_DATA;
    logic        FIX_VALID;
    logic [19:0] PBUS;
    logic        CA4;
    logic        S2H1;
    logic        PCK1B;
    logic        PCK2B;
    logic [31:0] CR;
    logic [7:0]  FIXD;

    int checks = 0;
    int errors = 0;

    pbus_fetch dut (
        .CLK_24M   (CLK_24M),
        .nRESET    (nRESET),
        .SPR_REQ   (SPR_REQ),
        .SPR_TILE  (SPR_TILE),
        .SPR_LINE  (SPR_LINE),
        .SPR_HALF  (SPR_HALF),
        .SPR_READY (SPR_READY),
        .SPR_DATA  (SPR_DATA),
        .SPR_VALID (SPR_VALID),
        .FIX_REQ   (FIX_REQ),
        .FIX_TILE  (FIX_TILE),
        .FIX_LINE  (FIX_LINE),
        .FIX_HALF  (FIX_HALF),
        .FIX_READY (FIX_READY),
        .FIX_DATA  (FIX_DATA),
        .FIX_VALID (FIX_VALID),
        .PBUS      (PBUS),
        .CA4       (CA4),
        .S2H1      (S2H1),
        .PCK1B     (PCK1B),
        .PCK2B     (PCK2B),
        .CR        (CR),
        .FIXD      (FIXD)
    );

    initial CLK_24M = 1'b0;
    always #5 CLK_24M = ~CLK_24M;

    task automatic tick();
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Holds reset low for a few edges, then checks the reset state.
    task automatic apply_reset();
        nRESET = 1'b0;
        repeat (3) tick();
        check_output("rst_pbus",  {12'd0, PBUS}, 32'h0);
        check_output("rst_pck1b", {31'd0, PCK1B}, 32'h1);
        check_output("rst_pck2b", {31'd0, PCK2B}, 32'h1);
        check_output("rst_ca4",   {31'd0, CA4}, 32'h0);
        check_output("rst_s2h1",  {31'd0, S2H1}, 32'h0);
        check_output("rst_sdata", SPR_DATA, 32'h0);
        check_output("rst_fdata", {24'd0, FIX_DATA}, 32'h0);
        check_output("rst_svld",  {31'd0, SPR_VALID}, 32'h0);
        check_output("rst_fvld",  {31'd0, FIX_VALID}, 32'h0);
        nRESET = 1'b1;
        tick();
        check_output("rst_srdy",  {31'd0, SPR_READY}, 32'h1);
        check_output("rst_frdy",  {31'd0, FIX_READY}, 32'h1);
    endtask

    // Drives one or both requests across a single rising edge (the accept
    // edge) and returns 1 unit after it.
    task automatic apply_stimulus(input logic spr, input logic [15:0] st,
                                  input logic [3:0] sl, input logic sh,
                                  input logic fix, input logic [11:0] ft,
                                  input logic [2:0] fl, input logic fh);
        SPR_REQ  = spr;
        SPR_TILE = st;
        SPR_LINE = sl;
        SPR_HALF = sh;
        FIX_REQ  = fix;
        FIX_TILE = ft;
        FIX_LINE = fl;
        FIX_HALF = fh;
        tick();
        SPR_REQ = 1'b0;
        FIX_REQ = 1'b0;
    endtask

    initial begin
        nRESET   = 1'b0;
        SPR_REQ  = 1'b0;
        SPR_TILE = 16'd0;
        SPR_LINE = 4'd0;
        SPR_HALF = 1'b0;
        FIX_REQ  = 1'b0;
        FIX_TILE = 12'd0;
        FIX_LINE = 3'd0;
        FIX_HALF = 1'b0;
        CR       = 32'd0;
        FIXD     = 8'd0;

        apply_reset();

        // ---- Sprite only ----
        $display("[TB] sprite only");
        CR = 32'hDEADBEEF;
        apply_stimulus(1'b1, 16'h1234, 4'd5, 1'b1, 1'b0, 12'h0, 3'd0, 1'b0);
        check_output("s1_ready_busy", {31'd0, SPR_READY}, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_output($sformatf("s1_pbus_k%0d", k), {12'd0, PBUS}, 32'h12345);
            check_output($sformatf("s1_ca4_k%0d", k), {31'd0, CA4}, 32'h1);
            check_output($sformatf("s1_pck1b_k%0d", k), {31'd0, PCK1B},
                         (k == 2) ? 32'h0 : 32'h1);
            check_output($sformatf("s1_pck2b_k%0d", k), {31'd0, PCK2B}, 32'h1);
            check_output($sformatf("s1_svld_k%0d", k), {31'd0, SPR_VALID},
                         (k == 7) ? 32'h1 : 32'h0);
            if (k == 7) begin
                check_output("s1_sdata", SPR_DATA, 32'hDEADBEEF);
                CR = 32'h0;
            end
        end
        check_output("s1_sdata_hold", SPR_DATA, 32'hDEADBEEF);
        check_output("s1_ready_free", {31'd0, SPR_READY}, 32'h1);

        // ---- Fix only ----
        $display("[TB] fix only");
        FIXD = 8'h5A;
        apply_stimulus(1'b0, 16'h0, 4'd0, 1'b0, 1'b1, 12'hABC, 3'd3, 1'b0);
        check_output("f1_ready_busy", {31'd0, FIX_READY}, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_output($sformatf("f1_pbus_k%0d", k), {12'd0, PBUS}, 32'h0ABC6);
            check_output($sformatf("f1_ca4_k%0d", k), {31'd0, CA4}, 32'h1);
            check_output($sformatf("f1_pck2b_k%0d", k), {31'd0, PCK2B},
                         (k == 2) ? 32'h0 : 32'h1);
            check_output($sformatf("f1_pck1b_k%0d", k), {31'd0, PCK1B}, 32'h1);
            check_output($sformatf("f1_fvld_k%0d", k), {31'd0, FIX_VALID},
                         (k == 6) ? 32'h1 : 32'h0);
        end
        check_output("f1_fdata", {24'd0, FIX_DATA}, 32'h5A);

        // ---- Both on the same edge after reset: sprite first ----
        $display("[TB] simultaneous requests");
        apply_reset();
        CR   = 32'hCAFEF00D;
        FIXD = 8'hA5;
        apply_stimulus(1'b1, 16'h0001, 4'd2, 1'b0, 1'b1, 12'h123, 3'd7, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_output($sformatf("b_pbus_k%0d", k), {12'd0, PBUS},
                         (k <= 7) ? 32'h00012 : 32'h0123E);
            check_output($sformatf("b_pck1b_k%0d", k), {31'd0, PCK1B},
                         (k == 2) ? 32'h0 : 32'h1);
            check_output($sformatf("b_pck2b_k%0d", k), {31'd0, PCK2B},
                         (k == 9) ? 32'h0 : 32'h1);
            check_output($sformatf("b_svld_k%0d", k), {31'd0, SPR_VALID},
                         (k == 7) ? 32'h1 : 32'h0);
            check_output($sformatf("b_fvld_k%0d", k), {31'd0, FIX_VALID},
                         (k == 13) ? 32'h1 : 32'h0);
            check_output($sformatf("b_srdy_k%0d", k), {31'd0, SPR_READY},
                         (k >= 7) ? 32'h1 : 32'h0);
            check_output($sformatf("b_frdy_k%0d", k), {31'd0, FIX_READY},
                         (k >= 13) ? 32'h1 : 32'h0);
            check_output($sformatf("b_nolow_k%0d", k), {31'd0, (PCK1B | PCK2B)}, 32'h1);
            if (k >= 8) begin
                check_output($sformatf("b_s2h1_k%0d", k), {31'd0, S2H1}, 32'h1);
            end
        end
        check_output("b_sdata", SPR_DATA, 32'hCAFEF00D);
        check_output("b_fdata", {24'd0, FIX_DATA}, 32'hA5);

        // ---- Second sprite request while one is in flight ----
        $display("[TB] request while busy");
        CR = 32'h11223344;
        apply_stimulus(1'b1, 16'h4321, 4'hA, 1'b0, 1'b0, 12'h0, 3'd0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) begin
                SPR_REQ  = 1'b1;
                SPR_TILE = 16'hFFFF;
                SPR_LINE = 4'hF;
                SPR_HALF = 1'b1;
            end
            tick();
            if (k == 3) begin
                SPR_REQ = 1'b0;
            end
            check_output($sformatf("i_pbus_k%0d", k), {12'd0, PBUS}, 32'h4321A);
            check_output($sformatf("i_ca4_k%0d", k), {31'd0, CA4}, 32'h0);
            check_output($sformatf("i_pck1b_k%0d", k), {31'd0, PCK1B},
                         (k == 2) ? 32'h0 : 32'h1);
            check_output($sformatf("i_svld_k%0d", k), {31'd0, SPR_VALID},
                         (k == 7) ? 32'h1 : 32'h0);
            check_output($sformatf("i_srdy_k%0d", k), {31'd0, SPR_READY},
                         (k >= 7) ? 32'h1 : 32'h0);
        end
        check_output("i_sdata", SPR_DATA, 32'h11223344);

        // ---- Reset during WAIT aborts the transaction ----
        $display("[TB] reset mid-transaction");
        CR = 32'h99999999;
        apply_stimulus(1'b1, 16'h0F0F, 4'd1, 1'b1, 1'b0, 12'h0, 3'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
        end
        check_output("r_pck1b_pre", {31'd0, PCK1B}, 32'h1);
        check_output("r_pbus_pre", {12'd0, PBUS}, 32'h0F0F1);
        nRESET = 1'b0;
        #1;
        check_output("r_pck1b", {31'd0, PCK1B}, 32'h1);
        check_output("r_pbus", {12'd0, PBUS}, 32'h0);
        check_output("r_ca4", {31'd0, CA4}, 32'h0);
        check_output("r_srdy", {31'd0, SPR_READY}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_output($sformatf("r_svld_k%0d", k), {31'd0, SPR_VALID}, 32'h0);
        end
        nRESET = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_output($sformatf("r_idle_svld_k%0d", k), {31'd0, SPR_VALID}, 32'h0);
            check_output($sformatf("r_idle_pck1b_k%0d", k), {31'd0, PCK1B}, 32'h1);
        end
        check_output("r_srdy_after", {31'd0, SPR_READY}, 32'h1);
        check_output("r_sdata_clr", SPR_DATA, 32'h0);

        CR = 32'h77777777;
        apply_stimulus(1'b1, 16'h0A0B, 4'd6, 1'b0, 1'b0, 12'h0, 3'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_output($sformatf("r2_pbus_k%0d", k), {12'd0, PBUS}, 32'h0A0B6);
            check_output($sformatf("r2_pck1b_k%0d", k), {31'd0, PCK1B},
                         (k == 2) ? 32'h0 : 32'h1);
            check_output($sformatf("r2_svld_k%0d", k), {31'd0, SPR_VALID},
                         (k == 7) ? 32'h1 : 32'h0);
        end
        check_output("r2_sdata", SPR_DATA, 32'h77777777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pbus_fetch.md
PBUS_FETCH -- requirements
Module: pbus_fetch

Interface
REQ-001 SHALL have parameter SPR_WAIT, default 3, meaning cycles between PCK1B rising edge and CR capture (legal 1..15).
REQ-002 SHALL have parameter FIX_WAIT, default 2, meaning cycles between PCK2B rising edge and FIXD capture (legal 1..15).
REQ-003 SHALL have ports, one per line:
 CLK_24M  in  1  sole clock, all state on rising edge
 nRESET  in  1  asynchronous active-low reset
 SPR_REQ  in  1  sprite fetch request, accepted when SPR_READY=1
 SPR_TILE  in  16  sprite tile number
 SPR_LINE  in  4  sprite line within tile
 SPR_HALF  in  1  sprite half select, driven onto CA4
 SPR_READY  out  1  sprite request slot free
 SPR_DATA  out  32  captured sprite bitplane word
 SPR_VALID  out  1  one-cycle strobe, SPR_DATA fresh
 FIX_REQ  in  1  fix fetch request, accepted when FIX_READY=1
 FIX_TILE  in  12  fix tile number
 FIX_LINE  in  3  fix line within tile
 FIX_HALF  in  1  fix column half, driven onto S2H1
 FIX_READY  out  1  fix request slot free
 FIX_DATA  out  8  captured fix byte
 FIX_VALID  out  1  one-cycle strobe, FIX_DATA fresh
 PBUS  out  20  multiplexed cartridge address
 CA4  out  1  sprite half select to cartridge
 S2H1  out  1  fix half select to cartridge
 PCK1B  out  1  sprite address latch, idle high, latch on rising edge
 PCK2B  out  1  fix address latch, idle high, latch on rising edge
 CR  in  32  sprite data from cartridge
 FIXD  in  8  fix data from cartridge

Function
REQ-004 SHALL hold one pending sprite and one pending fix request; SPR_READY = no sprite pending and none in flight; FIX_READY likewise.
REQ-005 SHALL register TILE/LINE/HALF with the request on the edge where REQ=1 and READY=1; REQ while READY=0 SHALL be ignored with no side effect.
REQ-006 SHALL run FSM states IDLE, ADDR, PULSE, HOLD, WAIT, each one cycle except WAIT.
REQ-007 In IDLE with one pending request, SHALL start it next edge (IDLE->ADDR); with both pending, SHALL start the kind not served last (round-robin); a request registered on the same edge is not eligible until the following IDLE cycle.
REQ-008 Sprite transaction: PBUS={SPR_TILE,SPR_LINE}, CA4=SPR_HALF from ADDR entry; PCK1B=0 during PULSE only; PCK1B=1 in HOLD (rising edge latches).
REQ-009 Fix transaction: PBUS={4'b0,FIX_TILE,FIX_LINE,1'b0}, S2H1=FIX_HALF from ADDR entry; PCK2B=0 during PULSE only.
REQ-010 PBUS/CA4/S2H1 SHALL be stable from ADDR through last WAIT cycle and SHALL keep their last value while IDLE.
REQ-011 WAIT SHALL last SPR_WAIT (sprite) or FIX_WAIT (fix) cycles, via 4-bit down-counter loaded in HOLD.
REQ-012 On the edge ending the last WAIT cycle SHALL capture CR into SPR_DATA (or FIXD into FIX_DATA), pulse matching VALID high for exactly one cycle, clear the pending flag, go to IDLE.
REQ-013 Latency from accepting edge (empty FSM) to VALID-high cycle SHALL be 4+WAIT cycles (sprite default 7, fix default 6).
REQ-014 PCK1B and PCK2B SHALL never be low simultaneously; at most one transaction in flight.
REQ-015 SPR_DATA/FIX_DATA SHALL hold value until next capture.
REQ-016 Back-to-back: next transaction's ADDR SHALL follow one IDLE cycle after capture.

Reset
REQ-017 nRESET low SHALL immediately force: FSM IDLE, pending flags clear, last-served=fix, PBUS=0, CA4=0, S2H1=0, PCK1B=1, PCK2B=1, SPR_DATA=0, FIX_DATA=0, SPR_VALID=0, FIX_VALID=0, counter=0.
REQ-018 Reset mid-transaction SHALL abort it with no VALID strobe; after release READY outputs SHALL be 1.

Verification
REQ-019 Sprite only: SPR_TILE=16'h1234, LINE=5, HALF=1, CR=32'hDEADBEEF -> PBUS=20'h12345, CA4=1, PCK1B low one cycle, SPR_VALID 7 cycles after accept, SPR_DATA=32'hDEADBEEF.
REQ-020 Fix only: FIX_TILE=12'hABC, LINE=3, HALF=0, FIXD=8'h5A -> PBUS=20'h0ABC6, PCK2B low one cycle, FIX_VALID 6 cycles after accept, FIX_DATA=8'h5A.
REQ-021 SPR_REQ and FIX_REQ same edge after reset -> sprite served first, fix ADDR one cycle after SPR_VALID; PCK1B/PCK2B never low together.
REQ-022 Second SPR_REQ (TILE=16'hFFFF) while sprite in flight -> ignored, SPR_READY=0, only first data returned.
REQ-023 nRESET low during WAIT -> PCK1B=1, PBUS=0, no SPR_VALID; after release SPR_READY=1 and new request completes normally.
